// File: rtl/ir_tx_scheduler.sv
// Two-requester NEC frame scheduler: round-robin enqueue into a small frame FIFO,
// then one-at-a-time dispatch to the IR transmitter with busy handshake, timeout and inter-frame gap.
module ir_tx_scheduler #(
    parameter int FIFO_DEPTH   = 4,
    parameter int GAP_CYCLES   = 50000,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                          iCLK_50,
    input  logic                          iRST,
    input  logic                          iREQ0_VALID,
    input  logic [7:0]                    iREQ0_ADDR,
    input  logic [7:0]                    iREQ0_CMD,
    output logic                          oREQ0_READY,
    input  logic                          iREQ1_VALID,
    input  logic [7:0]                    iREQ1_ADDR,
    input  logic [7:0]                    iREQ1_CMD,
    output logic                          oREQ1_READY,
    output logic                          oTX_SEND,
    output logic [7:0]                    oTX_ADDRESS,
    output logic [7:0]                    oTX_COMMAND,
    input  logic                          iTX_BUSY,
    output logic [$clog2(FIFO_DEPTH):0]   oFIFO_COUNT,
    output logic                          oTIMEOUT
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int TMAX = (GAP_CYCLES > BUSY_TIMEOUT) ? GAP_CYCLES : BUSY_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1'b1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1'b1);
    localparam logic [TW-1:0] TMR_ZERO  = TW'(1'b0);
    localparam logic [TW-1:0] TMR_ONE   = TW'(1'b1);
    // A zero gap still spends one cycle in GAP before returning to IDLE.
    localparam logic [TW-1:0] GAP_LAST  = (GAP_CYCLES == 0) ? TW'(1'b0) : TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] BUSY_LAST = TW'(BUSY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        GAP       = 3'd4
    } state_t;

    state_t          state_r;
    logic [TW-1:0]   timer_r;
    logic [15:0]     fifoMem_r [FIFO_DEPTH];
    logic [AW-1:0]   wrPtr_r;
    logic [AW-1:0]   rdPtr_r;
    logic [AW:0]     count_r;
    logic            rrPtr_r;

    logic            spaceAvail_s;
    logic            grant0_s;
    logic            grant1_s;
    logic            push_s;
    logic            pop_s;
    logic [15:0]     pushData_s;

    // Arbitration and FIFO control; space is judged on the registered count only.
    always_comb begin
        spaceAvail_s = !iRST && (count_r < DEPTH_CNT);
        grant0_s     = spaceAvail_s && iREQ0_VALID && (!iREQ1_VALID || !rrPtr_r);
        grant1_s     = spaceAvail_s && iREQ1_VALID && (!iREQ0_VALID || rrPtr_r);
        push_s       = grant0_s || grant1_s;
        pop_s        = (state_r == IDLE) && (count_r != {(AW+1){1'b0}}) && !iTX_BUSY;
        if (grant1_s) begin
            pushData_s = {iREQ1_ADDR, iREQ1_CMD};
        end else begin
            pushData_s = {iREQ0_ADDR, iREQ0_CMD};
        end
    end

    assign oREQ0_READY = grant0_s;
    assign oREQ1_READY = grant1_s;
    assign oFIFO_COUNT = count_r;

    // Frame storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge iCLK_50) begin
        if (push_s) begin
            fifoMem_r[wrPtr_r] <= pushData_s;
        end
    end

    // Queue pointers, occupancy and round-robin pointer.
    always_ff @(posedge iCLK_50) begin
        if (iRST) begin
            wrPtr_r <= {AW{1'b0}};
            rdPtr_r <= {AW{1'b0}};
            count_r <= {(AW+1){1'b0}};
            rrPtr_r <= 1'b0;
        end else begin
            if (push_s) begin
                wrPtr_r <= wrPtr_r + PTR_ONE;
                rrPtr_r <= grant0_s;
            end
            if (pop_s) begin
                rdPtr_r <= rdPtr_r + PTR_ONE;
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + CNT_ONE;
            end else if (pop_s && !push_s) begin
                count_r <= count_r - CNT_ONE;
            end
        end
    end

    // Dispatch sequencer: launch, busy handshake with timeout, then the inter-frame gap.
    always_ff @(posedge iCLK_50) begin
        if (iRST) begin
            state_r     <= IDLE;
            timer_r     <= TMR_ZERO;
            oTX_SEND    <= 1'b0;
            oTX_ADDRESS <= 8'h00;
            oTX_COMMAND <= 8'h00;
            oTIMEOUT    <= 1'b0;
        end else begin
            oTX_SEND <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        {oTX_ADDRESS, oTX_COMMAND} <= fifoMem_r[rdPtr_r];
                        oTX_SEND <= 1'b1;
                        state_r  <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    // The launch cycle itself counts toward the busy timeout.
                    timer_r <= TMR_ONE;
                    state_r <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (iTX_BUSY) begin
                        state_r <= WAIT_DONE;
                    end else if (timer_r >= BUSY_LAST) begin
                        oTIMEOUT <= 1'b1;
                        timer_r  <= TMR_ZERO;
                        state_r  <= GAP;
                    end else begin
                        timer_r <= timer_r + TMR_ONE;
                    end
                end
                WAIT_DONE: begin
                    if (!iTX_BUSY) begin
                        timer_r <= TMR_ZERO;
                        state_r <= GAP;
                    end
                end
                GAP: begin
                    if (timer_r >= GAP_LAST) begin
                        state_r <= IDLE;
                    end else begin
                        timer_r <= timer_r + TMR_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ir_tx_scheduler.sv
// Bench for ir_tx_scheduler: queue/timestamp reference model checked every cycle,
// a behavioural NEC transmitter, and directed scenarios with hand-computed expectations.
module tb_ir_tx_scheduler;

    localparam int DEPTH  = 4;
    localparam int GAP    = 6;
    localparam int BT     = 5;
    localparam int GAPEFF = (GAP == 0) ? 1 : GAP;

    logic        clk = 1'b0;
    logic        rst;
    logic        v0, v1;
    logic [7:0]  a0, c0, a1, c1;
    logic        ready0, ready1;
    logic        send;
    logic [7:0]  txA, txC;
    logic        busy;
    logic [2:0]  cnt;
    logic        tmo;

    always #5 clk = ~clk;

    ir_tx_scheduler #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP), .BUSY_TIMEOUT(BT)) dut (
        .iCLK_50(clk), .iRST(rst),
        .iREQ0_VALID(v0), .iREQ0_ADDR(a0), .iREQ0_CMD(c0), .oREQ0_READY(ready0),
        .iREQ1_VALID(v1), .iREQ1_ADDR(a1), .iREQ1_CMD(c1), .oREQ1_READY(ready1),
        .oTX_SEND(send), .oTX_ADDRESS(txA), .oTX_COMMAND(txC), .iTX_BUSY(busy),
        .oFIFO_COUNT(cnt), .oTIMEOUT(tmo)
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: actual %0h, required %0h", name, act, exp);
        end
    endtask

    // Behavioural transmitter: 0 = busy for txLen cycles after each send, 1 = stuck busy, 2 = never busy
    int   txMode = 0;
    int   txLen  = 4;
    int   left   = 0;
    logic sendSeen;
    initial begin
        busy = 1'b0;
        forever begin
            @(negedge clk);
            sendSeen = send;
            @(posedge clk);
            #2;
            if (txMode == 1) begin
                busy = 1'b1;
            end else if (txMode == 2) begin
                busy = 1'b0;
                left = 0;
            end else begin
                if (sendSeen === 1'b1) left = txLen;
                if (left > 0) begin
                    busy = 1'b1;
                    left--;
                end else begin
                    busy = 1'b0;
                end
            end
        end
    end

    // Reference model: frame queue, round-robin bit, and launch/free timestamps
    logic [15:0] q[$];
    bit          rr, mSend, mTmo, active, sawBusy, armed, prevTmo;
    logic [7:0]  mA, mC;
    int          launchAt, freeAt;
    int          cyc = 0;
    int          tmoRise = -1;
    int          grantCyc[$];
    int          grantReq[$];
    int          launchCycQ[$];
    logic [15:0] launchFrm[$];

    always @(negedge clk) begin
        bit space, e0, e1, pop;
        space = !rst && (q.size() < DEPTH);
        e0 = space && v0 && (!v1 || !rr);
        e1 = space && v1 && (!v0 || rr);
        if (armed) begin
            check("ready0", ready0, e0);
            check("ready1", ready1, e1);
            check("tx_send", send, mSend);
            check("tx_address", txA, mA);
            check("tx_command", txC, mC);
            check("timeout", tmo, mTmo);
            check("fifo_count", cnt, q.size());
        end
        if (ready0 === 1'b1 && v0 === 1'b1) begin grantCyc.push_back(cyc); grantReq.push_back(0); end
        if (ready1 === 1'b1 && v1 === 1'b1) begin grantCyc.push_back(cyc); grantReq.push_back(1); end
        if (send === 1'b1) begin launchCycQ.push_back(cyc); launchFrm.push_back({txA, txC}); end
        if (tmo === 1'b1 && !prevTmo) tmoRise = cyc;
        prevTmo = (tmo === 1'b1);

        if (rst) begin
            q.delete();
            rr = 0; mSend = 0; mA = 8'h00; mC = 8'h00; mTmo = 0;
            active = 0; freeAt = 0; armed = 1;
        end else begin
            if (active && cyc > launchAt) begin
                if (!sawBusy) begin
                    if (busy) begin
                        sawBusy = 1;
                    end else if (cyc == launchAt + BT - 1) begin
                        mTmo = 1; active = 0; freeAt = cyc + 1 + GAPEFF;
                    end
                end else if (!busy) begin
                    active = 0; freeAt = cyc + 1 + GAPEFF;
                end
            end
            pop = !active && (cyc >= freeAt) && (q.size() > 0) && !busy;
            mSend = 0;
            if (pop) begin
                {mA, mC} = q.pop_front();
                mSend = 1; active = 1; sawBusy = 0; launchAt = cyc + 1;
            end
            if (e0) begin
                q.push_back({a0, c0}); rr = 1;
            end else if (e1) begin
                q.push_back({a1, c1}); rr = 0;
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int g0, l0, l1, i0, i1, idx;
        logic [15:0] r0f [2];
        logic [15:0] r1f [2];
        logic [15:0] f3  [5];
        logic [15:0] expL [4];
        int expG [4];
        r0f  = '{16'h0101, 16'h0202};
        r1f  = '{16'h1111, 16'h1212};
        f3   = '{16'h3001, 16'h3002, 16'h3003, 16'h3004, 16'h3005};
        expL = '{16'h0101, 16'h1111, 16'h0202, 16'h1212};
        expG = '{0, 1, 0, 1};

        // Reset, with a requester knocking that must be refused
        rst = 1'b1; v0 = 1'b1; v1 = 1'b0; a0 = 8'hEE; c0 = 8'hEE; a1 = 8'h00; c1 = 8'h00;
        repeat (3) tick();
        @(negedge clk);
        check("rst_ready0", ready0, 0);
        check("rst_count", cnt, 0);
        check("rst_send", send, 0);
        check("rst_timeout", tmo, 0);
        check("rst_addr", {txA, txC}, 16'h0000);
        tick();
        v0 = 1'b0; rst = 1'b0;
        tick();

        // Single frame then a second: latency 2, spacing txLen + GAP + 3
        g0 = grantCyc.size(); l0 = launchCycQ.size();
        v0 = 1'b1; a0 = 8'h12; c0 = 8'h34; tick();
        a0 = 8'h56; c0 = 8'h78; tick();
        v0 = 1'b0;
        repeat (40) tick();
        check("s1_launches", launchCycQ.size() - l0, 2);
        if (launchCycQ.size() >= l0 + 2 && grantCyc.size() > g0) begin
            check("s1_frame0", launchFrm[l0], 16'h1234);
            check("s1_latency", launchCycQ[l0] - grantCyc[g0], 2);
            check("s1_frame1", launchFrm[l0 + 1], 16'h5678);
            check("s1_spacing", launchCycQ[l0 + 1] - launchCycQ[l0], 13);
        end

        // Contention: grants and launches alternate starting with requester 0
        rst = 1'b1; tick(); rst = 1'b0;
        g0 = grantCyc.size(); l0 = launchCycQ.size(); i0 = 0; i1 = 0;
        for (int k = 0; k < 12 && (i0 < 2 || i1 < 2); k++) begin
            v0 = (i0 < 2); v1 = (i1 < 2);
            {a0, c0} = (i0 < 2) ? r0f[i0] : 16'h0000;
            {a1, c1} = (i1 < 2) ? r1f[i1] : 16'h0000;
            @(negedge clk);
            if (ready0 === 1'b1) i0++;
            if (ready1 === 1'b1) i1++;
            tick();
        end
        v0 = 1'b0; v1 = 1'b0;
        repeat (60) tick();
        check("s2_grants", grantCyc.size() - g0, 4);
        check("s2_launches", launchCycQ.size() - l0, 4);
        if (grantReq.size() >= g0 + 4 && launchFrm.size() >= l0 + 4) begin
            for (int k = 0; k < 4; k++) begin
                check("s2_grant_order", grantReq[g0 + k], expG[k]);
                check("s2_launch_order", launchFrm[l0 + k], expL[k]);
            end
        end

        // Full queue with transmitter stuck busy, then push/pop collision at count 4
        rst = 1'b1; tick(); rst = 1'b0;
        txMode = 1; l0 = launchCycQ.size(); idx = 0;
        for (int k = 0; k < 6; k++) begin
            v1 = 1'b1; {a1, c1} = f3[idx];
            @(negedge clk);
            if (ready1 === 1'b1) idx++;
            tick();
        end
        check("s3_accepted", idx, 4);
        check("s3_count_full", cnt, 4);
        txMode = 0; {a1, c1} = f3[4];
        @(negedge clk);
        check("s3_ready_full_pop", ready1, 0);
        tick();
        check("s3_count_after_pop", cnt, 3);
        @(negedge clk);
        if (ready1 === 1'b1) idx++;
        tick();
        v1 = 1'b0;
        check("s3_accepted_all", idx, 5);
        repeat (80) tick();
        check("s3_launches", launchCycQ.size() - l0, 5);
        if (launchFrm.size() >= l0 + 5) begin
            for (int k = 0; k < 5; k++) check("s3_drain_order", launchFrm[l0 + k], f3[k]);
        end

        // Timeout: transmitter never busy
        rst = 1'b1; tick(); rst = 1'b0;
        txMode = 2; l0 = launchCycQ.size();
        v0 = 1'b1; {a0, c0} = 16'h4041; tick();
        {a0, c0} = 16'h4243; tick();
        v0 = 1'b0;
        repeat (40) tick();
        check("s4_launches", launchCycQ.size() - l0, 2);
        if (launchCycQ.size() >= l0 + 2) begin
            check("s4_timeout_latency", tmoRise - launchCycQ[l0], 5);
            check("s4_spacing", launchCycQ[l0 + 1] - launchCycQ[l0], 12);
            check("s4_frame1", launchFrm[l0 + 1], 16'h4243);
        end
        check("s4_timeout_sticky", tmo, 1);

        // Reset while waiting for the transmitter with three frames queued
        rst = 1'b1; tick(); rst = 1'b0;
        txMode = 0; txLen = 20; l0 = launchCycQ.size();
        for (int k = 0; k < 4; k++) begin
            v0 = 1'b1; {a0, c0} = 16'h5001 + 16'(k); tick();
        end
        v0 = 1'b0;
        check("s5_queued", cnt, 3);
        check("s5_first_launch", launchCycQ.size() - l0, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("s5_count_reset", cnt, 0);
        check("s5_timeout_reset", tmo, 0);
        l1 = launchCycQ.size();
        repeat (40) tick();
        check("s5_no_send", launchCycQ.size() - l1, 0);
        txLen = 4; g0 = grantCyc.size();
        v0 = 1'b1; {a0, c0} = 16'h5A5B; tick();
        v0 = 1'b0;
        repeat (10) tick();
        check("s5_new_launch", launchCycQ.size() - l1, 1);
        if (launchCycQ.size() > l1 && grantCyc.size() > g0) begin
            check("s5_new_frame", launchFrm[l1], 16'h5A5B);
            check("s5_new_latency", launchCycQ[l1] - grantCyc[g0], 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
